seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_pkg.sv | 36 +++
 rtl/seg_decode.sv | 32 +++
 rtl/seg_scan.sv | 110 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg
// Shared definitions for the seven-segment scanner: scan FSM state enum,
// special digit codes, active-low segment patterns ({g,f,e,d,c,b,a}) and
// an anode-pattern helper.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_SHOW    = 2'd0,
        ST_ADVANCE = 2'd1,
        ST_LATCH   = 2'd2
    } scan_state_t;

    localparam logic [10:0] NUM_DASH  = 11'd11;
    localparam logic [10:0] NUM_BLANK = 11'd12;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] AN_OFF = 8'hFF;

    // Active-low anode pattern with only position pos driven.
    function automatic logic [7:0] anode_on(input logic [2:0] pos);
        return ~(8'b0000_0001 << pos);
    endfunction

endpackage

// File: rtl/seg_decode.sv
// seg_decode
// Purely combinational digit-code to segment-pattern decoder.
// Ports:
//   code    - 11-bit digit code (0..9 digits, 11 dash, anything else blank)
//   pattern - 7-bit active-low segment pattern {g,f,e,d,c,b,a}
module seg_decode
    import seg_pkg::*;
(
    input  logic [10:0] code,
    output logic [6:0]  pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            11'd0:     pattern = SEG_0;
            11'd1:     pattern = SEG_1;
            11'd2:     pattern = SEG_2;
            11'd3:     pattern = SEG_3;
            11'd4:     pattern = SEG_4;
            11'd5:     pattern = SEG_5;
            11'd6:     pattern = SEG_6;
            11'd7:     pattern = SEG_7;
            11'd8:     pattern = SEG_8;
            11'd9:     pattern = SEG_9;
            NUM_DASH:  pattern = SEG_DASH;
            NUM_BLANK: pattern = SEG_BLANK;
            default:   pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// seg_scan
// Eight-digit multiplexed seven-segment scanner with per-digit blink and
// global blanking. Each digit slot is ADVANCE + LATCH + (DIV-2) SHOW cycles.
// Ports:
//   clk, rst      - system clock, async active-high reset
//   num, dot      - digit code / active-low dot for the position on light
//   blink_mask    - per-position blink enable
//   blank_all     - forces every anode off
//   light         - current scan position, drives the external digit selector
//   an, seg, dp   - registered active-low anode, segment and dot outputs
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIV          = 100000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] num,
    input  logic        dot,
    input  logic [7:0]  blink_mask,
    input  logic        blank_all,
    output logic [2:0]  light,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int              PW         = $clog2(DIV);
    localparam logic [PW-1:0]   PRE_LAST   = PW'(DIV - 3);
    localparam logic [7:0]      FRAME_LAST = 8'(BLINK_FRAMES - 1);

    scan_state_t   state;
    logic [PW-1:0] presc;
    logic [7:0]    frame_cnt;
    logic          blink_phase;
    logic          dot_q;
    logic [6:0]    num_pattern;
    logic          show_dark;
    logic [7:0]    show_an;

    seg_decode u_decode (
        .code    (num),
        .pattern (num_pattern)
    );

    // Outputs are registered for the state being entered, so blank/blink
    // inputs seen this cycle land on the anodes at the next edge.
    always_comb begin
        show_dark = blank_all | (blink_phase & blink_mask[light]);
        show_an   = show_dark ? AN_OFF : anode_on(light);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_LATCH;
            light       <= 3'd0;
            presc       <= '0;
            frame_cnt   <= 8'd0;
            blink_phase <= 1'b0;
            dot_q       <= 1'b1;
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            case (state)
                ST_ADVANCE: begin
                    light <= light + 3'd1;
                    if (light == 3'd7) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt   <= 8'd0;
                            blink_phase <= ~blink_phase;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                    state <= ST_LATCH;
                    an    <= AN_OFF;
                    dp    <= 1'b1;
                end
                ST_LATCH: begin
                    // Selector has had this whole cycle to settle on the new light.
                    seg   <= num_pattern;
                    dot_q <= dot;
                    presc <= '0;
                    state <= ST_SHOW;
                    an    <= show_an;
                    dp    <= show_dark ? 1'b1 : dot;
                end
                ST_SHOW: begin
                    if (presc == PRE_LAST) begin
                        state <= ST_ADVANCE;
                        an    <= AN_OFF;
                        dp    <= 1'b1;
                    end else begin
                        presc <= presc + PW'(1);
                        an    <= show_an;
                        dp    <= show_dark ? 1'b1 : dot_q;
                    end
                end
                default: begin
                    state <= ST_LATCH;
                    an    <= AN_OFF;
                    dp    <= 1'b1;
                end
            endcase
        end
    end

endmodule
